// File: rtl/dff_monitor.sv
// dff_monitor: checks a flip-flop under test by comparing its Q output
// against the D value that was driven one cycle earlier, for a fixed number
// of samples per run, and reports mismatch count and a pass/fail verdict.
// Optional feature: define DFF_MONITOR_FIRST_ERR_EN to add the first_err
// port, which records the sample index of the first mismatch in a run.
module dff_monitor #(
  parameter int N_SAMPLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             d_in,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count
`ifdef DFF_MONITOR_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t           state_reg;
  logic             exp_q_reg;
  logic             mismatch;
  logic             last_sample;
  logic [CNT_W-1:0] err_count_next;

  // Case inequality so an X/Z on q_in or a captured X on d_in counts as a
  // mismatch in simulation; synthesis treats it as a plain inequality.
  assign mismatch       = (q_in !== exp_q_reg);
  assign last_sample    = (sample_count == LAST_IDX);
  // Error counter saturates at its maximum instead of wrapping.
  assign err_count_next = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;

  // Run-control FSM; all outputs are registered and updated alongside state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
      exp_q_reg    <= 1'b0;
`ifdef DFF_MONITOR_FIRST_ERR_EN
      first_err    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= ARM;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
`ifdef DFF_MONITOR_FIRST_ERR_EN
            first_err    <= '0;
`endif
          end
        end
        ARM: begin
          // Prime the expected value; no comparison happens in this cycle.
          exp_q_reg <= d_in;
          state_reg <= RUN;
        end
        RUN: begin
          exp_q_reg    <= d_in;
          sample_count <= sample_count + 1'b1;
          if (mismatch) begin
            err_count <= err_count_next;
`ifdef DFF_MONITOR_FIRST_ERR_EN
            // err_count never returns to zero within a run, so zero means
            // this is the first mismatch.
            if (err_count == '0) begin
              first_err <= sample_count;
            end
`endif
          end
          if (last_sample) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_count == '0) && !mismatch;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
      endcase
    end
  end

endmodule
